// File: rtl/matrix_pkg.sv
// Shared constants and state encoding for the matrix multiplier datapath.
package matrix_pkg;

  localparam int N      = 10;
  localparam int ELEM_W = 16;
  localparam int OUT_W  = 8;
  localparam int SETTLE = 1;
  localparam int BEATS  = N * N * ELEM_W / OUT_W;

  typedef enum logic [1:0] {IDLE, WAIT, SEND} state_t;

endpackage

// File: rtl/matrix_result_streamer.sv
// Captures the multiplier's flat result on completion and streams it out as
// OUT_W beats, row-major, element 0 first, most significant byte first.
module matrix_result_streamer #(
  parameter int N      = matrix_pkg::N,
  parameter int ELEM_W = matrix_pkg::ELEM_W,
  parameter int OUT_W  = matrix_pkg::OUT_W,
  parameter int SETTLE = matrix_pkg::SETTLE
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      mult_done,
  input  logic [N*N*ELEM_W-1:0]     result,
  output logic [OUT_W-1:0]          out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      out_last,
  output logic                      busy,
  output logic                      stream_done,
  output logic                      overrun
);
  import matrix_pkg::*;

  localparam int TOTAL_W = N * N * ELEM_W;
  localparam int NBEATS  = TOTAL_W / OUT_W;
  localparam int BPE     = ELEM_W / OUT_W;
  localparam int BW      = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam int CW      = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(NBEATS - 1);
  localparam logic [BW-1:0] PENULT    = BW'(NBEATS - 2);
  localparam logic [CW-1:0] SETTLE_END = CW'(SETTLE - 1);

  // Reorders the flat bus so beat b sits at [b*OUT_W +: OUT_W]; bytes within
  // each element are swapped so the MSB byte leaves first.
  function automatic logic [TOTAL_W-1:0] msb_first(input logic [TOTAL_W-1:0] flat);
    logic [TOTAL_W-1:0] r;
    r = '0;
    for (int e = 0; e < N * N; e++) begin
      for (int j = 0; j < BPE; j++) begin
        r[(e*BPE + j)*OUT_W +: OUT_W] = flat[e*ELEM_W + (BPE-1-j)*OUT_W +: OUT_W];
      end
    end
    return r;
  endfunction

  state_t               state_q;
  logic                 md_q;
  logic [TOTAL_W-1:0]   shadow_q;
  logic [BW-1:0]        beat_q;
  logic [CW-1:0]        cnt_q;
  logic                 out_valid_q;
  logic                 out_last_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 ovr_q;
  logic                 rise;

  assign rise        = mult_done && !md_q;
  assign out_data    = shadow_q[OUT_W-1:0];
  assign out_valid   = out_valid_q;
  assign out_last    = out_last_q;
  assign busy        = busy_q;
  assign stream_done = done_q;
  assign overrun     = ovr_q;

  // Frame controller: edge detect, settle wait, shadow load and beat shifting.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      md_q        <= 1'b0;
      shadow_q    <= '0;
      beat_q      <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ovr_q       <= 1'b0;
    end else begin
      md_q   <= mult_done;
      done_q <= 1'b0;
      ovr_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (rise) begin
            busy_q <= 1'b1;
            beat_q <= '0;
            cnt_q  <= '0;
            if (SETTLE == 0) begin
              shadow_q    <= msb_first(result);
              out_valid_q <= 1'b1;
              out_last_q  <= (NBEATS == 1);
              state_q     <= SEND;
            end else begin
              state_q <= WAIT;
            end
          end
        end
        WAIT: begin
          if (rise) ovr_q <= 1'b1;
          if (cnt_q == SETTLE_END) begin
            shadow_q    <= msb_first(result);
            out_valid_q <= 1'b1;
            out_last_q  <= (NBEATS == 1);
            state_q     <= SEND;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        SEND: begin
          if (rise) ovr_q <= 1'b1;
          if (out_valid_q && out_ready) begin
            shadow_q <= shadow_q >> OUT_W;
            if (beat_q == LAST_BEAT) begin
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
              busy_q      <= 1'b0;
              done_q      <= 1'b1;
              state_q     <= IDLE;
            end else begin
              beat_q     <= beat_q + 1'b1;
              out_last_q <= (beat_q == PENULT);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_result_streamer.sv
// Randomized bench for matrix_result_streamer with a queue-based reference.
module tb_matrix_result_streamer;
  import matrix_pkg::*;

  localparam int EW  = ELEM_W;
  localparam int OW  = OUT_W;
  localparam int ST  = SETTLE;
  localparam int NB  = BEATS;
  localparam int BPE = EW / OW;
  localparam int TOT = N * N * EW;

  logic           clk = 1'b0;
  logic           rst;
  logic           mult_done;
  logic [TOT-1:0] result;
  logic [OW-1:0]  out_data;
  logic           out_valid;
  logic           out_ready = 1'b1;
  logic           out_last;
  logic           busy;
  logic           stream_done;
  logic           overrun;

  always #5 clk = ~clk;

  matrix_result_streamer #(.N(N), .ELEM_W(EW), .OUT_W(OW), .SETTLE(ST)) dut (
    .clk(clk), .rst(rst), .mult_done(mult_done), .result(result),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .busy(busy), .stream_done(stream_done), .overrun(overrun)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: a frame is simply the queue of bytes the sink must see.
  logic [OW-1:0] mq[$];
  bit  m_md, m_busy, m_done, m_ovr;
  int  m_wait = 0;
  bit  chk_en = 0;
  int  ready_mode = 0;
  int  clr_gen = 0;
  int  clr_seen = 0;

  int  acc_cnt, frames, ovr_seen, nlast, last_idx;
  logic [OW-1:0] log_b [0:NB-1];

  function automatic void load_frame();
    mq.delete();
    for (int k = 0; k < N * N; k++)
      for (int j = 0; j < BPE; j++)
        mq.push_back(result[k*EW + (BPE-1-j)*OW +: OW]);
  endfunction

  always @(posedge clk) begin
    bit rise, was_busy, acc;
    if (clr_gen != clr_seen) begin
      clr_seen = clr_gen;
      acc_cnt = 0; frames = 0; ovr_seen = 0; nlast = 0; last_idx = -1;
    end
    if (rst) begin
      mq.delete();
      m_md = 0; m_busy = 0; m_done = 0; m_ovr = 0; m_wait = 0;
    end else begin
      if (out_valid && out_ready) begin
        if (acc_cnt < NB) log_b[acc_cnt] = out_data;
        if (out_last) begin nlast++; last_idx = acc_cnt; end
        acc_cnt++;
      end
      if (stream_done) frames++;
      if (overrun) ovr_seen++;
      rise = mult_done && !m_md;
      m_md = mult_done;
      was_busy = m_busy;
      acc = (mq.size() > 0) && out_ready;
      m_done = 0; m_ovr = 0;
      if (acc) begin
        void'(mq.pop_front());
        if (mq.size() == 0) begin m_busy = 0; m_done = 1; end
      end else if (m_wait > 0) begin
        m_wait--;
        if (m_wait == 0) load_frame();
      end
      if (rise) begin
        if (was_busy) m_ovr = 1;
        else begin
          m_busy = 1;
          if (ST == 0) load_frame();
          else m_wait = ST;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("out_valid", 32'(out_valid), 32'(mq.size() > 0));
      if (mq.size() > 0) begin
        chk("out_data", 32'(out_data), 32'(mq[0]));
        chk("out_last", 32'(out_last), 32'(mq.size() == 1));
      end
      chk("busy", 32'(busy), 32'(m_busy));
      chk("stream_done", 32'(stream_done), 32'(m_done));
      chk("overrun", 32'(overrun), 32'(m_ovr));
    end
  end

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      1:       out_ready = ~out_ready;
      2:       out_ready = ($urandom_range(0, 3) != 0);
      default: out_ready = 1'b1;
    endcase
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic set_data(input int base);
    for (int k = 0; k < N * N; k++) result[k*EW +: EW] = EW'(base + k);
  endtask

  task automatic set_rand();
    for (int k = 0; k < N * N; k++) result[k*EW +: EW] = EW'($urandom);
  endtask

  task automatic clear_stats();
    clr_gen++;
    step(1);
  endtask

  task automatic wait_frames(input int target, input int budget);
    int c = 0;
    while (frames < target && c < budget) begin step(1); c++; end
    if (frames < target) begin
      n_cmp++; n_bad++;
      $display("FAIL wait_frames: got %0d frames expected %0d", frames, target);
    end
  endtask

  task automatic wait_acc(input int target, input int budget);
    int c = 0;
    while (acc_cnt < target && c < budget) begin step(1); c++; end
    if (acc_cnt < target) begin
      n_cmp++; n_bad++;
      $display("FAIL wait_acc: got %0d beats expected %0d", acc_cnt, target);
    end
  endtask

  initial begin
    rst = 1'b1; mult_done = 1'b0; result = '0;
    step(2);
    chk_en = 1;
    step(2);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_out_last", 32'(out_last), 0);
    rst = 1'b0;

    // 1: counting data, ready high, 5-cycle done level
    clear_stats();
    set_data(16'h0100); ready_mode = 0;
    mult_done = 1'b1; step(5); mult_done = 1'b0;
    wait_frames(1, 600); step(3);
    chk("t1_beats", acc_cnt, 200);
    chk("t1_b0", 32'(log_b[0]), 32'h01);
    chk("t1_b1", 32'(log_b[1]), 32'h00);
    chk("t1_b2", 32'(log_b[2]), 32'h01);
    chk("t1_b3", 32'(log_b[3]), 32'h01);
    chk("t1_b199", 32'(log_b[199]), 32'h63);
    chk("t1_nlast", nlast, 1);
    chk("t1_last_idx", last_idx, 199);

    // 2: ready toggling
    clear_stats();
    ready_mode = 1;
    mult_done = 1'b1; step(3); mult_done = 1'b0;
    wait_frames(1, 1000); step(3);
    chk("t2_beats", acc_cnt, 200);
    chk("t2_b0", 32'(log_b[0]), 32'h01);
    chk("t2_b3", 32'(log_b[3]), 32'h01);
    chk("t2_b199", 32'(log_b[199]), 32'h63);
    chk("t2_last_idx", last_idx, 199);

    // 3: level held for 500 cycles
    clear_stats();
    ready_mode = 2; set_rand();
    mult_done = 1'b1; step(500);
    chk("t3_frames", frames, 1);
    chk("t3_overrun", ovr_seen, 0);
    chk("t3_busy", 32'(busy), 0);
    mult_done = 1'b0; step(2);

    // 4: second rise at beat 40
    clear_stats();
    ready_mode = 0; set_data(16'h0200);
    mult_done = 1'b1; step(2); mult_done = 1'b0;
    wait_acc(40, 200);
    mult_done = 1'b1; set_data(16'h0300);
    wait_frames(1, 600); step(20);
    chk("t4_frames", frames, 1);
    chk("t4_overrun", ovr_seen, 1);
    chk("t4_beats", acc_cnt, 200);
    chk("t4_b80", 32'(log_b[80]), 32'h02);
    chk("t4_b81", 32'(log_b[81]), 32'h28);
    mult_done = 1'b0; step(2);

    // 5: reset mid-frame, then a new frame
    clear_stats();
    set_data(16'h0400);
    mult_done = 1'b1; step(2); mult_done = 1'b0;
    wait_acc(57, 200);
    rst = 1'b1; step(1); rst = 1'b0;
    chk("t5_valid_after_rst", 32'(out_valid), 0);
    chk("t5_busy_after_rst", 32'(busy), 0);
    step(3);
    set_data(16'hA000);
    clear_stats();
    mult_done = 1'b1; step(2); mult_done = 1'b0;
    wait_frames(1, 600); step(2);
    chk("t5_b0", 32'(log_b[0]), 32'hA0);
    chk("t5_b1", 32'(log_b[1]), 32'h00);
    chk("t5_b3", 32'(log_b[3]), 32'h01);
    chk("t5_beats", acc_cnt, 200);

    // 6: result changes right after latch; quick re-rise after stream_done
    clear_stats();
    set_data(16'h0500);
    mult_done = 1'b1; step(1); step(1);
    set_data(16'h0600); mult_done = 1'b0;
    wait_frames(1, 600);
    chk("t6_b0", 32'(log_b[0]), 32'h05);
    chk("t6_b198", 32'(log_b[198]), 32'h05);
    chk("t6_b199", 32'(log_b[199]), 32'h63);
    clear_stats();
    step(1);
    mult_done = 1'b1; step(1); mult_done = 1'b0;
    wait_frames(1, 600); step(2);
    chk("t6_frame2_b0", 32'(log_b[0]), 32'h06);
    chk("t6_frame2_beats", acc_cnt, 200);

    // random pulses, data and backpressure
    ready_mode = 2;
    for (int it = 0; it < 8; it++) begin
      set_rand();
      mult_done = 1'b1; step($urandom_range(1, 8));
      mult_done = 1'b0; step($urandom_range(0, 300));
    end
    begin
      int c = 0;
      while ((busy || out_valid) && c < 2000) begin step(1); c++; end
      chk("rand_drain_busy", 32'(busy), 0);
    end
    step(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
